// File: rtl/clock_timekeeper_pkg.sv
// Shared encodings and BCD helpers for the MM:SS time-of-day core.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'b00,
    MODE_STOPWATCH = 2'b01,
    MODE_SET       = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC_L = 2'b00,
    POS_SEC_H = 2'b01,
    POS_MIN_L = 2'b10,
    POS_MIN_H = 2'b11
  } pos_e;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
    return (d == max) ? '0 : d + 4'd1;
  endfunction

  // Odd positions hold tens digits.
  function automatic logic [3:0] digit_max(input pos_e p);
    return p[0] ? TENS_MAX : UNITS_MAX;
  endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// Mode/button inputs and display-facing outputs of the timekeeper.
interface clock_timekeeper_if;
  logic [1:0] switch_mode;
  logic       btn_next_n;
  logic       btn_inc_n;
  logic [3:0] clock_min_H;
  logic [3:0] clock_min_L;
  logic [3:0] clock_sec_H;
  logic [3:0] clock_sec_L;
  logic [1:0] pos_set;
  logic       sec_pulse;

  modport master (
    output switch_mode, btn_next_n, btn_inc_n,
    input  clock_min_H, clock_min_L, clock_sec_H, clock_sec_L, pos_set, sec_pulse
  );

  modport slave (
    input  switch_mode, btn_next_n, btn_inc_n,
    output clock_min_H, clock_min_L, clock_sec_H, clock_sec_L, pos_set, sec_pulse
  );
endinterface

// File: rtl/clock_timekeeper_debounce.sv
// 2-FF synchroniser plus counter debouncer; emits one pulse per accepted press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 20
) (
  input  logic clk_1khz,
  input  logic system_reset,
  input  logic btn_n,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge clk_1khz or negedge system_reset) begin
    if (!system_reset) begin
      r_sync  <= '1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // Sample DEBOUNCE_CYC in a row differs from the accepted level.
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign press = r_press;
endmodule

// File: rtl/clock_timekeeper.sv
// MM:SS BCD timekeeper with prescaler, carry chain and push-button digit editing.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned DEBOUNCE_CYC  = 20
) (
  input logic               clk_1khz,
  input logic               system_reset,
  clock_timekeeper_if.slave bus
);
  localparam int unsigned PW = $clog2(TICKS_PER_SEC);

  logic [PW-1:0] r_presc;
  logic [3:0]    r_dig [4];
  pos_e          r_pos;
  logic          r_sec_pulse;

  mode_e w_mode;
  logic  w_running;
  logic  w_tick;
  logic  w_set;
  logic  w_next;
  logic  w_inc;

  assign w_mode    = mode_e'(bus.switch_mode);
  assign w_running = (w_mode == MODE_CLOCK) || (w_mode == MODE_STOPWATCH);
  assign w_set     = (w_mode == MODE_SET);
  assign w_tick    = w_running && (r_presc == PW'(TICKS_PER_SEC - 1));

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk_1khz     (clk_1khz),
    .system_reset (system_reset),
    .btn_n        (bus.btn_next_n),
    .press        (w_next)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk_1khz     (clk_1khz),
    .system_reset (system_reset),
    .btn_n        (bus.btn_inc_n),
    .press        (w_inc)
  );

  always_ff @(posedge clk_1khz or negedge system_reset) begin
    if (!system_reset) begin
      r_presc     <= '0;
      r_dig       <= '{default: '0};
      r_pos       <= POS_SEC_L;
      r_sec_pulse <= 1'b0;
    end else begin
      r_sec_pulse <= w_tick;
      r_presc     <= (!w_running || w_tick) ? '0 : r_presc + PW'(1);

      if (w_tick) begin
        r_dig[POS_SEC_L] <= bcd_inc(r_dig[POS_SEC_L], UNITS_MAX);
        if (r_dig[POS_SEC_L] == UNITS_MAX) begin
          r_dig[POS_SEC_H] <= bcd_inc(r_dig[POS_SEC_H], TENS_MAX);
          if (r_dig[POS_SEC_H] == TENS_MAX) begin
            r_dig[POS_MIN_L] <= bcd_inc(r_dig[POS_MIN_L], UNITS_MAX);
            if (r_dig[POS_MIN_L] == UNITS_MAX)
              r_dig[POS_MIN_H] <= bcd_inc(r_dig[POS_MIN_H], TENS_MAX);
          end
        end
      end else if (w_set && w_inc) begin
        // Edit uses the pre-advance position when both buttons fire together.
        r_dig[r_pos] <= bcd_inc(r_dig[r_pos], digit_max(r_pos));
      end

      if (!w_set)
        r_pos <= POS_SEC_L;
      else if (w_next)
        r_pos <= pos_e'(r_pos + 2'd1);
    end
  end

  assign bus.clock_sec_L = r_dig[POS_SEC_L];
  assign bus.clock_sec_H = r_dig[POS_SEC_H];
  assign bus.clock_min_L = r_dig[POS_MIN_L];
  assign bus.clock_min_H = r_dig[POS_MIN_H];
  assign bus.pos_set     = r_pos;
  assign bus.sec_pulse   = r_sec_pulse;
endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
Time-of-day core that sits directly upstream of the four-digit seven-segment display driver and feeds it. It keeps MM:SS in BCD from the 1 kHz system clock, and supplies the clock digits and the blinking-digit selector pos_set. In time-set mode it halts counting and lets two push-buttons select a digit and increment it. The display driver consumes clock_min_H/L, clock_sec_H/L and pos_set unchanged.

Parameters:
TICKS_PER_SEC, 1000, clk_1khz cycles per second; prescaler terminal count is TICKS_PER_SEC-1.
DEBOUNCE_CYC, 20, consecutive stable cycles before a button level is accepted (20 ms at 1 kHz).

Ports:
clk_1khz  in  1  system clock, 1 kHz
system_reset  in  1  asynchronous, active-low reset
switch_mode  in  2  00 clock, 01 stopwatch, 10 time-set, 11 hold
btn_next_n  in  1  raw push-button, active-low; advances the edit position
btn_inc_n  in  1  raw push-button, active-low; increments the selected digit
clock_min_H  out  4  BCD minutes tens, 0-5
clock_min_L  out  4  BCD minutes units, 0-9
clock_sec_H  out  4  BCD seconds tens, 0-5
clock_sec_L  out  4  BCD seconds units, 0-9
pos_set  out  2  edit position: 00 sec_L, 01 sec_H, 10 min_L, 11 min_H
sec_pulse  out  1  one-cycle strobe on every counted second

Behaviour:
- Clock and reset: clk_1khz is the single clock. system_reset is asynchronous and active-low. On reset all four digits go to 0, pos_set goes to 00, sec_pulse goes to 0, the prescaler goes to 0, and the debouncer state clears.
- Prescaler: counts 0..TICKS_PER_SEC-1 and wraps.
  - It runs only in mode 00 or 01, so the clock keeps time in the background while the stopwatch is shown.
  - In mode 10 and mode 11 it is held at 0.
- Second tick: when the prescaler equals TICKS_PER_SEC-1 in a running mode:
  - The digits update on that same clock edge; the new value is visible 1 cycle after the terminal count.
  - sec_pulse is registered high for exactly that one cycle.
- Carry chain for a counted second:
  - sec_L 9 wraps to 0 and carries to sec_H.
  - sec_H 5 wraps to 0 and carries to min_L.
  - min_L 9 wraps to 0 and carries to min_H.
  - min_H 5 wraps to 0.
  - 59:59 becomes 00:00 in a single tick.
- Digit range: values above the digit maximum are unreachable by construction; no other digit state exists.
- Time-set mode (10):
  - Counting is frozen and sec_pulse stays 0.
  - A next-press advances pos_set 00→01→10→11→00.
  - An inc-press increments only the digit selected by pos_set, wrapping modulo its own range (sec_L and min_L 0-9, sec_H and min_H 0-5).
  - An inc-press never carries into a neighbouring digit.
- Simultaneous next-press and inc-press in the same cycle: the increment is applied to the old pos_set, then pos_set advances.
- Presses outside mode 10 are ignored: they are still debounced and consumed, with no effect.
- Mode exit: on any cycle where switch_mode != 10, pos_set is forced to 00. When re-entering mode 00 or 01, the prescaler starts from 0, so the first tick arrives TICKS_PER_SEC cycles later.
- Mode 11 (hold): digits frozen, no edits, pos_set 00.
- Mode change on a terminal-count cycle: the tick is evaluated using the switch_mode sampled on that edge.
- Buttons:
  - Each button is synchronised with a 2-FF synchroniser, then debounced: the accepted level changes only after DEBOUNCE_CYC consecutive identical synchronised samples.
  - A press is a one-cycle pulse on the accepted high→low transition of the _n input.
  - Holding a button produces exactly one press; there is no auto-repeat.
  - Press-pulse latency from a clean edge: 2 sync + DEBOUNCE_CYC + 1 cycles.
- Reset asserted mid-operation (including mid-debounce or mid-edit): immediate return to all reset values, with no pending press surviving.

Decomposition:
- Shared package clock_pkg holds:
  - Mode encodings: MODE_CLOCK=2'b00, MODE_STOPWATCH=2'b01, MODE_SET=2'b10, MODE_HOLD=2'b11.
  - Position encodings: POS_SEC_L=00, POS_SEC_H=01, POS_MIN_L=10, POS_MIN_H=11.
  - Digit maxima: UNITS_MAX=9, TENS_MAX=5.
- Sub-module button_debounce (parameter DEBOUNCE_CYC; ports clk_1khz, system_reset, btn_n, press) is instantiated twice.
- Prescaler, BCD carry chain and edit logic stay in the top module.

Test Plan:
- Reset, then mode 00 for 3×TICKS_PER_SEC cycles → digits read 00:03; sec_pulse high for exactly 3 single cycles, each 1 cycle after a terminal count.
- Preload 59:58 via set mode, return to mode 00, run 2 s → 59:59 then 00:00; min_H/min_L/sec_H/sec_L all 0 on the same edge.
- Mode 10, pos_set 01, sec_H=5, one clean inc-press → sec_H=0, sec_L unchanged, no minute carry. Four next-presses → pos_set cycles 10,11,00,01.
- btn_inc_n bounces 5 times with 3-cycle glitches, then holds low 50 cycles → exactly one increment, occurring 2+20+1 cycles after the final stable edge.
- Mode 10 at 12:34 with next and inc pressed on the same cycle at pos 00 → 12:35, pos_set=01. Switching to mode 01 → pos_set=00, first sec_pulse exactly 1000 cycles later.
- Assert system_reset mid-count at 07:42 and mid-debounce → all outputs 0 asynchronously; after release no spurious press, and counting restarts from 00:00.
